// File: rtl/mult_pkg.sv
// Shared types and constants for the chunked sequential multiplier.
package mult_pkg;
  localparam int CHUNK_W = 4;
  localparam int CORE_OW = 8;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Operand/result handshakes plus the link to the external 4b x 4b core.
interface mult_seq_ctrl_if #(parameter int OPW = 8);
  import mult_pkg::*;
  localparam int ACCW = 2*OPW;

  logic                in_valid;
  logic                in_ready;
  logic [OPW-1:0]      in_a;
  logic [OPW-1:0]      in_b;
  logic                flush;
  logic [CHUNK_W-1:0]  mul_x;
  logic [CHUNK_W-1:0]  mul_y;
  logic [CORE_OW-1:0]  mul_o;
  logic                out_valid;
  logic                out_ready;
  logic [ACCW-1:0]     out_prod;
  logic                busy;

  // master: producer/consumer side that also hosts the core
  modport master (
    output in_valid, in_a, in_b, flush, out_ready, mul_o,
    input  in_ready, out_valid, out_prod, busy, mul_x, mul_y
  );

  modport slave (
    input  in_valid, in_a, in_b, flush, out_ready, mul_o,
    output in_ready, out_valid, out_prod, busy, mul_x, mul_y
  );
endinterface

// File: rtl/mult_acc_dp.sv
// Chunk select, partial-product shift and accumulate for one job.
module mult_acc_dp
  import mult_pkg::*;
#(
  parameter int OPW = 8,
  parameter int IW  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPW-1:0]      a_q,
  input  logic [OPW-1:0]      b_q,
  input  logic [IW-1:0]       i,
  input  logic [IW-1:0]       j,
  input  logic [CORE_OW-1:0]  mul_o,
  input  logic                clr,
  input  logic                en,
  output logic [CHUNK_W-1:0]  mul_x,
  output logic [CHUNK_W-1:0]  mul_y,
  output logic [2*OPW-1:0]    acc
);
  localparam int ACCW = 2*OPW;

  logic [ACCW-1:0] term;

  // core inputs depend only on registers, keeping the core in a single reg-to-reg path
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    if (en) begin
      mul_x = a_q[CHUNK_W*int'(i) +: CHUNK_W];
      mul_y = b_q[CHUNK_W*int'(j) +: CHUNK_W];
    end
    term = ACCW'(mul_o) << (CHUNK_W*(int'(i) + int'(j)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + term;
  end
endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer: walks all chunk pairs through the shared 4b core and returns a*b.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int OPW = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  mult_seq_ctrl_if.slave bus
);
  localparam int NCHUNK = OPW / CHUNK_W;
  localparam int ACCW   = 2*OPW;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK-1);

  state_t          state, state_nx;
  logic [OPW-1:0]  a_q, b_q;
  logic [IW-1:0]   i, j;
  logic            calc, accept, last;
  logic [ACCW-1:0] acc;

  always_comb begin
    calc     = (state == CALC);
    accept   = (state == IDLE) && bus.in_valid && !bus.flush;
    last     = calc && (i == LAST) && (j == LAST);
    state_nx = state;
    case (state)
      IDLE:    if (accept)        state_nx = CALC;
      CALC:    if (last)          state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
    if (bus.flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // j is the inner index; i advances when j wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      i   <= '0;
      j   <= '0;
    end else if (accept) begin
      a_q <= bus.in_a;
      b_q <= bus.in_b;
      i   <= '0;
      j   <= '0;
    end else if (calc && !bus.flush) begin
      if (j == LAST) begin
        j <= '0;
        i <= (i == LAST) ? '0 : i + IW'(1);
      end else begin
        j <= j + IW'(1);
      end
    end
  end

  mult_acc_dp #(.OPW(OPW), .IW(IW)) u_dp (
    .clk   (clk),
    .rst_n (rst_n),
    .a_q   (a_q),
    .b_q   (b_q),
    .i     (i),
    .j     (j),
    .mul_o (bus.mul_o),
    .clr   (accept || bus.flush),
    .en    (calc),
    .mul_x (bus.mul_x),
    .mul_y (bus.mul_y),
    .acc   (acc)
  );

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_prod  = acc;
endmodule
